// File: rtl/fp8_pkg.sv
// fp8_pkg: shared widths, packed float type and FSM states for the fp8 datapath.
package fp8_pkg;
  localparam int EXP_W  = 3;
  localparam int FRAC_W = 4;
  localparam int BIAS   = 3;
  localparam int MANT_W = FRAC_W + 3;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W:0] EXP_MAX = (1 << EXP_W) - 1;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] fract;
  } fp8_t;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
endpackage

// File: rtl/fp8_rne_round.sv
// fp8_rne_round: round-to-nearest-even and pack a normalized mantissa, saturating on overflow.
module fp8_rne_round
  import fp8_pkg::*;
(
  input  logic              sign,
  input  logic [FRAC_W:0]   mant,
  input  logic [EXP_W:0]    exp,
  input  logic              sticky,
  output fp8_t              result,
  output logic              ovf
);
  logic              up;
  logic [FRAC_W:0]   sum;
  logic [EXP_W:0]    exp_r;
  // mant is {fract, guard}; hidden bit is implied
  assign up    = mant[0] & (sticky | mant[1]);
  assign sum   = {1'b0, mant[FRAC_W:1]} + {{FRAC_W{1'b0}}, up};
  assign exp_r = exp + {{EXP_W{1'b0}}, sum[FRAC_W]};
  assign ovf   = exp_r > EXP_MAX;
  always_comb begin
    result.sign  = sign;
    result.exp   = ovf ? '1 : exp_r[EXP_W-1:0];
    result.fract = ovf ? '1 : sum[FRAC_W-1:0];
  end
endmodule

// File: rtl/fp8_norm_round.sv
// fp8_norm_round: sequential one-bit-per-cycle normalizer feeding the RNE rounder, with valid/ready on both sides.
module fp8_norm_round
  import fp8_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      result_o,
  output logic              ovf_o,
  output logic              unf_o,
  output logic              zero_o
);
  state_t            state;
  logic [MANT_W-1:0] mant;
  logic [EXP_W:0]    exp;
  logic              sticky;
  logic              sign;
  fp8_t              rnd_res;
  logic              rnd_ovf;
  logic              carry, hidden, to_zero;
  assign carry   = mant[MANT_W-1];
  assign hidden  = mant[MANT_W-2];
  // exact zero, zero exponent, or no room left to shift left: result is flushed
  assign to_zero = mant == '0 || exp == '0 ||
                   (!carry && !hidden && exp == {{EXP_W{1'b0}}, 1'b1});
  fp8_rne_round u_round (
    .sign   (sign),
    .mant   (mant[FRAC_W:0]),
    .exp    (exp),
    .sticky (sticky),
    .result (rnd_res),
    .ovf    (rnd_ovf)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
      zero_o      <= 1'b0;
      mant        <= '0;
      exp         <= '0;
      sticky      <= 1'b0;
      sign        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          sign       <= sign_i;
          exp        <= {1'b0, exp_i};
          mant       <= mant_i;
          sticky     <= 1'b0;
          in_ready_o <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: if (to_zero) begin
          result_o    <= {sign, {(W-1){1'b0}}};
          zero_o      <= 1'b1;
          unf_o       <= mant != '0;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end else if (carry) begin
          mant   <= mant >> 1;
          sticky <= sticky | mant[0];
          exp    <= exp + 1'b1;
          state  <= ROUND;
        end else if (hidden) begin
          state <= ROUND;
        end else begin
          mant <= mant << 1;
          exp  <= exp - 1'b1;
        end
        ROUND: begin
          result_o    <= rnd_res;
          ovf_o       <= rnd_ovf;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          result_o    <= '0;
          ovf_o       <= 1'b0;
          unf_o       <= 1'b0;
          zero_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
